seg_tube_ctrl: RTL and testbench

Memory-mapped 8-digit seven-segment display controller on the CPU I/O bus, alongside the LED and switch ports. It consumes the same I/O write strobe, chip select, low address bits and 16-bit write data that MemOrIO drives to the LED port. It holds a 32-bit hex display value plus a control register. It time-multiplexes the digits with a refresh counter, driving active-low digit enables and segments.

---
 rtl/tube_pkg.sv | 25 ++
 rtl/seg_hex_decode.sv | 11 +
 rtl/seg_tube_ctrl.sv | 104 ++++++++++
 tb/tb_seg_tube_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tube_pkg.sv
// Shared constants for the seven-segment tube controller: register map,
// reset values and the active-low glyph table ({g,f,e,d,c,b,a}).
package tube_pkg;

   localparam int DIGITS = 8;

   localparam logic [2:0] TUBE_ADDR_LO    = 3'h0;
   localparam logic [2:0] TUBE_ADDR_HI    = 3'h2;
   localparam logic [2:0] TUBE_ADDR_CTRL  = 3'h4;
   localparam logic [2:0] TUBE_ADDR_BLINK = 3'h6;

   localparam logic [15:0] TUBE_CTRL_RST = 16'h00FF;

   // Entry n is the glyph for hex digit n; a lit segment is 0.
   localparam logic [15:0][6:0] SEG_LUT = {
      7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

   typedef struct packed {
      logic [2:0]  addr;
      logic [15:0] data;
   } tube_wr_t;

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern {g..a}.
module seg_hex_decode
   import tube_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   assign seg = SEG_LUT[nibble];

endmodule

// File: rtl/seg_tube_ctrl.sv
// 8-digit multiplexed seven-segment controller on the CPU I/O bus.
// Optional `TUBE_BLINK_EN adds a BLINK mask register at 0x6 and a blink timer.
module seg_tube_ctrl
   import tube_pkg::*;
#(
   parameter int SCAN_DIV = 50000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        tubecs,
   input  logic        tubewrite,
   input  logic [2:0]  tubeaddr,
   input  logic [15:0] tubewdata,
   output logic [7:0]  seg_en,
   output logic [7:0]  seg_out
);

   localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

   logic [CW-1:0] scan_cnt;
   logic [2:0]    idx;
   logic [15:0]   data_lo, data_hi, ctrl;
   logic          wr_en;
   tube_wr_t      wr;
   logic [31:0]   disp;
   logic [3:0]    nibble;
   logic [6:0]    hex_seg;
   logic          blank;
   logic          digit_on;

   assign wr_en = tubecs & tubewrite;
   assign wr    = '{addr: tubeaddr, data: tubewdata};

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         data_lo <= '0;
         data_hi <= '0;
         ctrl    <= TUBE_CTRL_RST;
      end else if (wr_en) begin
         case (wr.addr)
            TUBE_ADDR_LO:   data_lo <= wr.data;
            TUBE_ADDR_HI:   data_hi <= wr.data;
            TUBE_ADDR_CTRL: ctrl    <= wr.data;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         scan_cnt <= '0;
         idx      <= '0;
      end else if (scan_cnt == CW'(SCAN_DIV - 1)) begin
         scan_cnt <= '0;
         idx      <= idx + 3'd1;
      end else begin
         scan_cnt <= scan_cnt + CW'(1);
      end
   end

`ifdef TUBE_BLINK_EN
   logic [7:0]  blink_mask;
   logic [23:0] blink_cnt;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         blink_mask <= '0;
         blink_cnt  <= '0;
      end else begin
         blink_cnt <= blink_cnt + 24'd1;
         if (wr_en && wr.addr == TUBE_ADDR_BLINK)
            blink_mask <= wr.data[7:0];
      end
   end

   // Blinking digits go dark during the upper half of the timer period.
   assign blank = blink_cnt[23] & blink_mask[idx];
`else
   assign blank = 1'b0;
`endif

   assign disp     = {data_hi, data_lo};
   assign nibble   = disp[{idx, 2'b00} +: 4];
   assign digit_on = ctrl[idx] & ~blank;

   seg_hex_decode u_hex (
      .nibble (nibble),
      .seg    (hex_seg)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         seg_en  <= 8'hFF;
         seg_out <= 8'hFF;
      end else if (digit_on) begin
         seg_en  <= ~(8'b1 << idx);
         seg_out <= {~ctrl[8 + int'(idx)], hex_seg};
      end else begin
         seg_en  <= 8'hFF;
         seg_out <= 8'hFF;
      end
   end

endmodule

// File: tb/tb_seg_tube_ctrl.sv
// Randomized bench for seg_tube_ctrl against a cycle-count display model.
module tb_seg_tube_ctrl;

   localparam int D = 4;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        tubecs = 1'b0;
   logic        tubewrite = 1'b0;
   logic [2:0]  tubeaddr = '0;
   logic [15:0] tubewdata = '0;
   logic [7:0]  seg_en, seg_out;

   int checks = 0;
   int errors = 0;

   // Model state: registers plus number of clock edges since reset release.
   logic [15:0] m_lo, m_hi, m_ctrl;
   logic [7:0]  m_blink;
   logic        m_blk_hi;
   int          m_k;
   logic [7:0]  e_en, e_seg;

   string glyph[16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg",
                        "acdefg", "abc", "abcdefg", "abcdfg", "abcefg",
                        "cdefg", "adef", "bcdeg", "adefg", "aefg"};

   seg_tube_ctrl #(.SCAN_DIV(D)) dut (
      .clock     (clock),
      .reset     (reset),
      .tubecs    (tubecs),
      .tubewrite (tubewrite),
      .tubeaddr  (tubeaddr),
      .tubewdata (tubewdata),
      .seg_en    (seg_en),
      .seg_out   (seg_out)
   );

   always #5 clock = ~clock;

   function automatic logic [6:0] lit(input int v);
      string s = glyph[v];
      logic [6:0] r = '0;
      for (int i = 0; i < s.len(); i++) r[int'(s[i]) - 97] = 1'b1;
      return r;
   endfunction

   task automatic model_reset();
      m_lo = '0; m_hi = '0; m_ctrl = 16'h00FF; m_blink = '0; m_blk_hi = 1'b0; m_k = 0;
   endtask

   // Expected outputs for the next edge: the digit lit is the one whose slot
   // covers this edge's position in the scan, using pre-edge register values.
   task automatic calc_exp();
      int d = (m_k / D) % 8;
      logic [31:0] v = {m_hi, m_lo};
      int nib = int'((v >> (4 * d)) & 32'hF);
      if (m_ctrl[d] && !(m_blk_hi && m_blink[d])) begin
         e_en  = ~(8'b1 << d);
         e_seg = {~m_ctrl[8 + d], ~lit(nib)};
      end else begin
         e_en  = 8'hFF;
         e_seg = 8'hFF;
      end
   endtask

   task automatic step(input logic cs, input logic we, input logic [2:0] a, input logic [15:0] dat);
      tubecs = cs; tubewrite = we; tubeaddr = a; tubewdata = dat;
      calc_exp();
      if (cs && we) begin
         case (a)
            3'h0: m_lo = dat;
            3'h2: m_hi = dat;
            3'h4: m_ctrl = dat;
`ifdef TUBE_BLINK_EN
            3'h6: m_blink = dat[7:0];
`endif
            default: ;
         endcase
      end
      @(posedge clock); #1;
      m_k++;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         @(posedge clock); #1;
         checks++;
         if (seg_en !== 8'hFF || seg_out !== 8'hFF) begin
            errors++;
            $display("FAIL reset_state en=%h exp=FF seg=%h exp=FF", seg_en, seg_out);
         end
      end
      model_reset();
      @(negedge clock) reset = 1'b0;
   endtask

   task automatic test_scan();
      step(1'b0, 1'b0, 3'h0, 16'h0);
      checks++;
      if (seg_en !== 8'hFE || seg_out !== 8'hC0) begin
         errors++;
         $display("FAIL first_digit en=%h exp=FE seg=%h exp=C0", seg_en, seg_out);
      end
      for (int i = 0; i < 8 * D + 8; i++) begin
         step(1'b0, 1'b0, 3'h0, 16'h0);
         checks++;
         if (seg_en !== e_en || seg_out !== e_seg) begin
            errors++;
            $display("FAIL scan k=%0d en=%h exp=%h seg=%h exp=%h", m_k, seg_en, e_en, seg_out, e_seg);
         end
      end
   endtask

   task automatic test_data();
      step(1'b1, 1'b1, 3'h0, 16'h1234);
      step(1'b1, 1'b1, 3'h2, 16'h89AB);
      for (int i = 0; i < 8 * D + 2; i++) begin
         step(1'b0, 1'b1, 3'h0, 16'h0);
         checks++;
         if (seg_en !== e_en || seg_out !== e_seg) begin
            errors++;
            $display("FAIL data k=%0d en=%h exp=%h seg=%h exp=%h", m_k, seg_en, e_en, seg_out, e_seg);
         end
         if (seg_en === 8'hFE && seg_out !== 8'h99) begin
            errors++;
            $display("FAIL digit0_glyph seg=%h exp=99", seg_out);
         end
         if (seg_en === 8'h7F && seg_out !== 8'h80) begin
            errors++;
            $display("FAIL digit7_glyph seg=%h exp=80", seg_out);
         end
      end
   endtask

   task automatic test_ctrl();
      step(1'b1, 1'b1, 3'h4, 16'h0F0F);
      for (int i = 0; i < 8 * D + 2; i++) begin
         step(1'b0, 1'b0, 3'h4, 16'h0);
         checks++;
         if (seg_en !== e_en || seg_out !== e_seg) begin
            errors++;
            $display("FAIL ctrl k=%0d en=%h exp=%h seg=%h exp=%h", m_k, seg_en, e_en, seg_out, e_seg);
         end
      end
   endtask

   task automatic test_ignored();
      logic [2:0] addrs[4] = '{3'h1, 3'h5, 3'h7, 3'h3};
      step(1'b0, 1'b1, 3'h0, 16'hFFFF);
      step(1'b0, 1'b1, 3'h4, 16'h0000);
      for (int j = 0; j < 4; j++) step(1'b1, 1'b1, addrs[j], 16'hA5A5);
`ifndef TUBE_BLINK_EN
      step(1'b1, 1'b1, 3'h6, 16'h0000);
`endif
      for (int i = 0; i < 8 * D; i++) begin
         step(1'b0, 1'b0, 3'h0, 16'h0);
         checks++;
         if (seg_en !== e_en || seg_out !== e_seg) begin
            errors++;
            $display("FAIL ignored_write k=%0d en=%h exp=%h seg=%h exp=%h", m_k, seg_en, e_en, seg_out, e_seg);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         logic [2:0] a = 3'($urandom_range(0, 7));
`ifdef TUBE_BLINK_EN
         if (a == 3'h6) a = 3'h7;
`endif
         step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), a, 16'($urandom));
         checks++;
         if (seg_en !== e_en || seg_out !== e_seg) begin
            errors++;
            $display("FAIL random k=%0d en=%h exp=%h seg=%h exp=%h", m_k, seg_en, e_en, seg_out, e_seg);
         end
      end
   endtask

`ifdef TUBE_BLINK_EN
   task automatic test_blink();
      step(1'b1, 1'b1, 3'h4, 16'h00FF);
      step(1'b1, 1'b1, 3'h6, 16'h0001);
      for (int ph = 0; ph < 2; ph++) begin
         if (ph == 0) begin force dut.blink_cnt = 24'h800000; m_blk_hi = 1'b1; end
         else begin force dut.blink_cnt = 24'h000000; m_blk_hi = 1'b0; end
         for (int i = 0; i < 8 * D; i++) begin
            step(1'b0, 1'b0, 3'h0, 16'h0);
            checks++;
            if (seg_en !== e_en || seg_out !== e_seg) begin
               errors++;
               $display("FAIL blink k=%0d en=%h exp=%h seg=%h exp=%h", m_k, seg_en, e_en, seg_out, e_seg);
            end
         end
      end
      release dut.blink_cnt;
   endtask
`endif

   task automatic test_reset_mid();
      step(1'b1, 1'b1, 3'h4, 16'h00FF);
      for (int i = 0; i < 16 * D && !(((m_k / D) % 8) == 5 && (m_k % D) == 2); i++)
         step(1'b0, 1'b0, 3'h0, 16'h0);
      checks++;
      if (seg_en !== 8'hDF) begin
         errors++;
         $display("FAIL pre_reset_digit5 en=%h exp=DF", seg_en);
      end
      tubecs = 1'b1; tubewrite = 1'b1; tubeaddr = 3'h2; tubewdata = 16'h7777;
      @(negedge clock); #2;
      reset = 1'b1;
      #1;
      checks++;
      if (seg_en !== 8'hFF || seg_out !== 8'hFF) begin
         errors++;
         $display("FAIL async_reset en=%h exp=FF seg=%h exp=FF", seg_en, seg_out);
      end
      @(posedge clock); #1;
      checks++;
      if (seg_en !== 8'hFF || seg_out !== 8'hFF) begin
         errors++;
         $display("FAIL reset_hold en=%h exp=FF seg=%h exp=FF", seg_en, seg_out);
      end
      tubecs = 1'b0; tubewrite = 1'b0;
      model_reset();
      @(negedge clock) reset = 1'b0;
      for (int i = 0; i < 8 * D + 4; i++) begin
         step(1'b0, 1'b0, 3'h0, 16'h0);
         checks++;
         if (seg_en !== e_en || seg_out !== e_seg) begin
            errors++;
            $display("FAIL post_reset k=%0d en=%h exp=%h seg=%h exp=%h", m_k, seg_en, e_en, seg_out, e_seg);
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_scan();
      test_data();
      test_ctrl();
      test_ignored();
      test_random();
`ifdef TUBE_BLINK_EN
      test_blink();
`endif
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
